// File: rtl/pq_pkg.sv
// ---------------------------------------------------------------------------
// pq_pkg -- shared types and helpers for the parametrised heap priority queue.
//
// Contents:
//   KEY_MAX_W     widest key the ordering helper accepts
//   heap_state_e  heap controller states
//   idx_width()   index/count width for a given capacity
//   kv_width()    packed {key,value} width
//   better()      heap ordering predicate, selectable min/max
// ---------------------------------------------------------------------------
package pq_pkg;

    // Keys are zero-extended to this width before comparison, so KEY_W must
    // not exceed it.
    localparam int KEY_MAX_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        EN_WR,
        EN_CMP,
        DQ_LD,
        HP_RD,
        HP_CMP
    } heap_state_e;

    // Index 0 is unused (1-based heap), so CAPACITY+1 addresses are needed.
    function automatic int idx_width(input int capacity);
        return $clog2(capacity + 1);
    endfunction

    function automatic int kv_width(input int key_w, input int val_w);
        return key_w + val_w;
    endfunction

    // Strict comparison: equal keys never count as better, so ties never swap.
    function automatic logic better(input logic                 max_heap,
                                    input logic [KEY_MAX_W-1:0] a,
                                    input logic [KEY_MAX_W-1:0] b);
        return max_heap ? (a > b) : (a < b);
    endfunction

endpackage

// File: rtl/pq_mem_2r1w.sv
// ---------------------------------------------------------------------------
// pq_mem_2r1w -- heap storage with one write port and two read ports.
// Both reads are registered: data appears the cycle after the address.
//
// Ports:
//   clk      clock
//   we       write enable
//   waddr    write address
//   din      write data
//   raddr_a  read address, port A
//   raddr_b  read address, port B
//   dout_a   registered read data, port A
//   dout_b   registered read data, port B
// ---------------------------------------------------------------------------
module pq_mem_2r1w #(
    parameter  int W  = 16,
    parameter  int D  = 16,
    localparam int AW = (D > 1) ? $clog2(D) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  din,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  dout_a,
    output logic [W-1:0]  dout_b
);

    logic [W-1:0] mem [D];

    // NOTE: the array has no reset; the occupancy count alone decides which
    // entries are live, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
        dout_a <= mem[raddr_a];
        dout_b <= mem[raddr_b];
    end

endmodule

// File: rtl/heap_pq_param.sv
// ---------------------------------------------------------------------------
// heap_pq_param -- parametrised binary-heap priority queue, min or max mode.
// One operation in flight; requests are only sampled while busy is low.
//
// Ports:
//   clk    clock
//   rst    synchronous active-high reset (aborts any operation, empties queue)
//   enq    enqueue request
//   deq    dequeue request (enq & deq on a non-empty queue replaces the root)
//   kvi    {key,value} to insert, key in the MSBs
//   kvo    registered root entry, valid while empty is low
//   full   count == CAPACITY
//   empty  count == 0
//   busy   an operation is in progress
//   count  number of stored entries
//   ovf    one-cycle pulse: enqueue dropped because full
//   unf    one-cycle pulse: dequeue dropped because empty
// ---------------------------------------------------------------------------
module heap_pq_param
    import pq_pkg::*;
#(
    parameter  int KEY_W    = 8,
    parameter  int VAL_W    = 8,
    parameter  int CAPACITY = 15,
    parameter  bit MAX_HEAP = 1'b0,
    localparam int IW       = idx_width(CAPACITY),
    localparam int KVW      = kv_width(KEY_W, VAL_W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enq,
    input  logic           deq,
    input  logic [KVW-1:0] kvi,
    output logic [KVW-1:0] kvo,
    output logic           full,
    output logic           empty,
    output logic           busy,
    output logic [IW-1:0]  count,
    output logic           ovf,
    output logic           unf
);

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } kv_t;

    function automatic logic beats(input kv_t a, input kv_t b);
        return better(MAX_HEAP, KEY_MAX_W'(a.key), KEY_MAX_W'(b.key));
    endfunction

    heap_state_e   state_q;
    logic [IW-1:0] count_q;
    logic [IW-1:0] ni_q;
    kv_t           i_kv_q;
    kv_t           kvo_q;
    logic          ovf_q;
    logic          unf_q;

    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    kv_t           mem_din;
    logic [IW-1:0] mem_raddr_a;
    logic [IW-1:0] mem_raddr_b;
    kv_t           mem_dout_a;
    kv_t           mem_dout_b;

    pq_mem_2r1w #(
        .W (KVW),
        .D (CAPACITY + 1)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .din     (mem_din),
        .raddr_a (mem_raddr_a),
        .raddr_b (mem_raddr_b),
        .dout_a  (mem_dout_a),
        .dout_b  (mem_dout_b)
    );

    logic empty_w;
    logic full_w;
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == IW'(CAPACITY));

    // Child indices carry one extra bit: for a leaf, 2*ni can exceed the
    // IW-bit range and must still compare as "beyond count".
    logic [IW:0]   left_w;
    logic [IW:0]   right_w;
    logic          left_ok;
    logic          right_ok;
    logic [IW-1:0] parent_w;
    assign left_w   = {ni_q, 1'b0};
    assign right_w  = {ni_q, 1'b1};
    assign left_ok  = (left_w <= {1'b0, count_q});
    assign right_ok = (right_w <= {1'b0, count_q});
    assign parent_w = ni_q >> 1;

    // Better child: right only when it exists and strictly beats left.
    logic          right_wins;
    kv_t           child_kv;
    logic [IW-1:0] child_idx;
    logic          en_swap;
    logic          hp_swap;
    assign right_wins = right_ok && beats(mem_dout_b, mem_dout_a);
    assign child_kv   = right_wins ? mem_dout_b : mem_dout_a;
    assign child_idx  = right_wins ? right_w[IW-1:0] : left_w[IW-1:0];
    assign en_swap    = beats(i_kv_q, mem_dout_a);
    assign hp_swap    = beats(child_kv, i_kv_q);

    // Command decode; enq & deq on a non-empty queue takes precedence as a
    // replace, whether or not the queue is full.
    logic cmd_replace;
    logic cmd_enq;
    logic cmd_deq;
    logic cmd_ovf;
    logic cmd_unf;
    assign cmd_replace = enq && deq && !empty_w;
    assign cmd_enq     = enq && !full_w && !cmd_replace;
    assign cmd_deq     = deq && !empty_w && !enq;
    assign cmd_ovf     = enq && full_w && !deq;
    assign cmd_unf     = deq && empty_w && !enq;

    // NOTE: every output of this block gets a default before the case, so no
    // state leaves a signal unassigned and no latch is inferred.
    always_comb begin
        mem_we      = 1'b0;
        mem_waddr   = ni_q;
        mem_din     = i_kv_q;
        mem_raddr_a = '0;
        mem_raddr_b = '0;
        unique case (state_q)
            IDLE: begin
                // Prefetch the last entry in case this cycle accepts a dequeue.
                mem_raddr_a = count_q;
            end
            EN_WR: begin
                mem_we      = 1'b1;
                mem_raddr_a = parent_w;
            end
            EN_CMP: begin
                mem_we  = en_swap;
                mem_din = mem_dout_a;
            end
            HP_RD: begin
                mem_we = 1'b1;
                // Only address the children when they exist; a truncated
                // right index could otherwise alias the write address.
                if (left_ok) begin
                    mem_raddr_a = left_w[IW-1:0];
                    mem_raddr_b = right_w[IW-1:0];
                end
            end
            HP_CMP: begin
                mem_we  = hp_swap;
                mem_din = child_kv;
            end
            default: begin
            end
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            ni_q    <= '0;
            i_kv_q  <= '0;
            kvo_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;

            // kvo mirrors the root: capture whatever is written to address 1.
            if (mem_we && (mem_waddr == IW'(1))) begin
                kvo_q <= mem_din;
            end

            unique case (state_q)
                IDLE: begin
                    i_kv_q <= kvi;
                    if (cmd_replace) begin
                        ni_q    <= IW'(1);
                        state_q <= HP_RD;
                    end else if (cmd_enq) begin
                        count_q <= count_q + 1'b1;
                        ni_q    <= count_q + 1'b1;
                        state_q <= EN_WR;
                    end else if (cmd_deq) begin
                        count_q <= count_q - 1'b1;
                        state_q <= DQ_LD;
                    end else begin
                        ovf_q <= cmd_ovf;
                        unf_q <= cmd_unf;
                    end
                end
                EN_WR: begin
                    state_q <= (ni_q == IW'(1)) ? IDLE : EN_CMP;
                end
                EN_CMP: begin
                    if (en_swap) begin
                        ni_q    <= parent_w;
                        state_q <= EN_WR;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DQ_LD: begin
                    // The former last entry restarts at the root and sifts down.
                    i_kv_q  <= mem_dout_a;
                    ni_q    <= IW'(1);
                    state_q <= (count_q == '0) ? IDLE : HP_RD;
                end
                HP_RD: begin
                    state_q <= left_ok ? HP_CMP : IDLE;
                end
                HP_CMP: begin
                    if (hp_swap) begin
                        ni_q    <= child_idx;
                        state_q <= HP_RD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign kvo   = kvo_q;
    assign full  = full_w;
    assign empty = empty_w;
    assign busy  = (state_q != IDLE);
    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_heap_pq_param.sv
// ---------------------------------------------------------------------------
// tb_heap_pq_param -- scoreboard bench for heap_pq_param.
// Two instances: index 0 is a min-heap, index 1 a max-heap. The driver
// applies each request to a bag-of-entries model, pushes the expected
// post-operation view, and a monitor pops and compares whenever a DUT
// finishes an operation (busy falls) or pulses ovf/unf.
// ---------------------------------------------------------------------------
module tb_heap_pq_param;

    localparam int KEY_W = 8;
    localparam int VAL_W = 8;
    localparam int CAP   = 15;
    localparam int IW    = 4;
    localparam int KVW   = KEY_W + VAL_W;

    logic           clk = 1'b0;
    logic           rst;
    logic           enq   [2];
    logic           deq   [2];
    logic [KVW-1:0] kvi   [2];
    logic [KVW-1:0] kvo   [2];
    logic           full  [2];
    logic           empty [2];
    logic           busy  [2];
    logic [IW-1:0]  count [2];
    logic           ovf   [2];
    logic           unf   [2];

    always #5 clk = ~clk;

    heap_pq_param #(.KEY_W(KEY_W), .VAL_W(VAL_W), .CAPACITY(CAP), .MAX_HEAP(1'b0)) dut_min (
        .clk(clk), .rst(rst), .enq(enq[0]), .deq(deq[0]), .kvi(kvi[0]), .kvo(kvo[0]),
        .full(full[0]), .empty(empty[0]), .busy(busy[0]), .count(count[0]),
        .ovf(ovf[0]), .unf(unf[0])
    );

    heap_pq_param #(.KEY_W(KEY_W), .VAL_W(VAL_W), .CAPACITY(CAP), .MAX_HEAP(1'b1)) dut_max (
        .clk(clk), .rst(rst), .enq(enq[1]), .deq(deq[1]), .kvi(kvi[1]), .kvo(kvo[1]),
        .full(full[1]), .empty(empty[1]), .busy(busy[1]), .count(count[1]),
        .ovf(ovf[1]), .unf(unf[1])
    );

    typedef struct {
        bit chk_key;
        bit chk_val;
        int key;
        int val;
        int cnt;
        bit emp;
        bit ful;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: an unordered bag per instance; the root is found by
    // scanning for the extreme key.
    logic [KVW-1:0] bag   [2][CAP];
    int             bag_n [2];
    bit             chk_vals = 1'b1;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit mdl_better(input int d, input int ka, input int kb);
        return (d == 1) ? (ka > kb) : (ka < kb);
    endfunction

    function automatic int best_idx(input int d);
        int b = 0;
        for (int i = 1; i < bag_n[d]; i++) begin
            if (mdl_better(d, int'(bag[d][i][KVW-1:VAL_W]), int'(bag[d][b][KVW-1:VAL_W]))) b = i;
        end
        return b;
    endfunction

    function automatic bit key_in_bag(input int d, input int key);
        for (int i = 0; i < bag_n[d]; i++) begin
            if (int'(bag[d][i][KVW-1:VAL_W]) == key) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void bag_remove_best(input int d);
        int b = best_idx(d);
        bag[d][b] = bag[d][bag_n[d]-1];
        bag_n[d]--;
    endfunction

    function automatic void bag_insert(input int d, input logic [KVW-1:0] kv);
        bag[d][bag_n[d]] = kv;
        bag_n[d]++;
    endfunction

    function automatic exp_t mk_exp(input int d, input bit o, input bit u);
        exp_t e = '{default: 0};
        e.cnt = bag_n[d];
        e.emp = (bag_n[d] == 0);
        e.ful = (bag_n[d] == CAP);
        e.ovf = o;
        e.unf = u;
        if (bag_n[d] > 0) begin
            int b = best_idx(d);
            e.chk_key = 1'b1;
            e.chk_val = chk_vals;
            e.key     = int'(bag[d][b][KVW-1:VAL_W]);
            e.val     = int'(bag[d][b][VAL_W-1:0]);
        end
        return e;
    endfunction

    task automatic push_exp(input int d, input exp_t e);
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // Issue one request at a falling edge and wait until the DUT is idle.
    // lat returns the number of cycles busy was high.
    task automatic do_op(input int d, input bit e, input bit q, input int key, output int lat);
        logic [KVW-1:0] kv;
        bit o = 1'b0;
        bit u = 1'b0;
        kv = {key[KEY_W-1:0], VAL_W'($urandom_range(0, 255))};
        if (e && q && bag_n[d] > 0) begin
            bag_remove_best(d);
            bag_insert(d, kv);
        end else if (e && bag_n[d] < CAP) begin
            bag_insert(d, kv);
        end else if (q && bag_n[d] > 0) begin
            bag_remove_best(d);
        end else if (e) begin
            o = 1'b1;
        end else if (q) begin
            u = 1'b1;
        end
        if (e || q) push_exp(d, mk_exp(d, o, u));
        enq[d] = e;
        deq[d] = q;
        kvi[d] = kv;
        @(negedge clk);
        enq[d] = 1'b0;
        deq[d] = 1'b0;
        lat = 0;
        while (busy[d] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (busy[d]) check($sformatf("d%0d busy timeout", d), 1, 0);
    endtask

    task automatic rand_key(input int d, output int key);
        if (chk_vals) begin
            do key = $urandom_range(0, 255); while (key_in_bag(d, key));
        end else begin
            key = $urandom_range(0, 15);
        end
    endtask

    // Abort a dequeue while it is sifting; the queue must come back empty.
    task automatic reset_mid_op();
        int   lat;
        int   k;
        exp_t e;
        while (bag_n[0] < 3) begin
            rand_key(0, k);
            do_op(0, 1'b1, 1'b0, k, lat);
        end
        e     = '{default: 0};
        e.emp = 1'b1;
        push_exp(0, e);
        deq[0] = 1'b1;
        @(negedge clk);
        deq[0] = 1'b0;
        check("busy during sift", busy[0], 1);
        rst = 1'b1;
        @(negedge clk);
        check("busy after reset", busy[0], 0);
        check("empty after reset", empty[0], 1);
        rst = 1'b0;
        bag_n[0] = 0;
        bag_n[1] = 0;
    endtask

    // Monitor: one expected entry per finished operation or drop pulse.
    logic prev_busy [2] = '{1'b0, 1'b0};

    task automatic mon_step(input int d);
        exp_t e;
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            check($sformatf("d%0d unexpected output event", d), 1, 0);
        end else begin
            e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            check($sformatf("d%0d count", d), int'(count[d]), e.cnt);
            check($sformatf("d%0d empty", d), int'(empty[d]), int'(e.emp));
            check($sformatf("d%0d full", d), int'(full[d]), int'(e.ful));
            check($sformatf("d%0d ovf", d), int'(ovf[d]), int'(e.ovf));
            check($sformatf("d%0d unf", d), int'(unf[d]), int'(e.unf));
            if (e.chk_key) check($sformatf("d%0d kvo.key", d), int'(kvo[d][KVW-1:VAL_W]), e.key);
            if (e.chk_val) check($sformatf("d%0d kvo.val", d), int'(kvo[d][VAL_W-1:0]), e.val);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if ((prev_busy[d] && !busy[d]) || ovf[d] || unf[d]) mon_step(d);
            prev_busy[d] <= busy[d];
        end
    end

    initial begin
        int lat;
        int k;
        int r;
        int p_enq;
        int keys4 [4] = '{5, 3, 8, 1};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            enq[d] = 1'b0;
            deq[d] = 1'b0;
            kvi[d] = '0;
            bag_n[d] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d reset kvo", d), int'(kvo[d]), 0);
            check($sformatf("d%0d reset count", d), int'(count[d]), 0);
            check($sformatf("d%0d reset empty", d), int'(empty[d]), 1);
            check($sformatf("d%0d reset full", d), int'(full[d]), 0);
            check($sformatf("d%0d reset busy", d), int'(busy[d]), 0);
            check($sformatf("d%0d reset ovf", d), int'(ovf[d]), 0);
            check($sformatf("d%0d reset unf", d), int'(unf[d]), 0);
        end

        // Min-heap: 5,3,8,1 in, then drained in order 1,3,5,8.
        do_op(0, 1'b1, 1'b0, 5, lat); check("lat enq into empty", lat, 1);
        do_op(0, 1'b1, 1'b0, 3, lat); check("lat enq climb 1", lat, 3);
        do_op(0, 1'b1, 1'b0, 8, lat);
        do_op(0, 1'b1, 1'b0, 1, lat); check("lat enq climb 2", lat, 5);
        do_op(0, 1'b0, 1'b1, 0, lat); check("lat deq descend 1", lat, 4);
        do_op(0, 1'b0, 1'b1, 0, lat);
        do_op(0, 1'b0, 1'b1, 0, lat); check("lat deq descend 0", lat, 2);
        do_op(0, 1'b0, 1'b1, 0, lat); check("lat deq last", lat, 1);

        // Max-heap: root 8, then 5 after one dequeue.
        foreach (keys4[i]) do_op(1, 1'b1, 1'b0, keys4[i], lat);
        do_op(1, 1'b0, 1'b1, 0, lat);

        // Fill to capacity with 15..1, then overflow with key 0.
        for (int i = CAP; i >= 1; i--) do_op(0, 1'b1, 1'b0, i, lat);
        do_op(0, 1'b1, 1'b0, 0, lat);
        @(negedge clk);
        check("ovf pulse width", int'(ovf[0]), 0);
        for (int i = 0; i < CAP; i++) do_op(0, 1'b0, 1'b1, 0, lat);

        // Underflow, then enq&deq on empty behaves as a plain enqueue.
        do_op(0, 1'b0, 1'b1, 0, lat);
        @(negedge clk);
        check("unf pulse width", int'(unf[0]), 0);
        do_op(0, 1'b1, 1'b1, 7, lat);
        do_op(0, 1'b0, 1'b1, 0, lat);

        // Replace on {2,4,6} with 5: root becomes 4, then 5 after a dequeue.
        do_op(0, 1'b1, 1'b0, 2, lat);
        do_op(0, 1'b1, 1'b0, 4, lat);
        do_op(0, 1'b1, 1'b0, 6, lat);
        do_op(0, 1'b1, 1'b1, 5, lat);
        do_op(0, 1'b0, 1'b1, 0, lat);

        // Random mix: narrow keys with ties first, unique keys after the reset.
        chk_vals = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                reset_mid_op();
                chk_vals = 1'b1;
            end
            p_enq = ((i / 150) % 2 == 0) ? 60 : 30;
            r = $urandom_range(0, 99);
            rand_key(0, k);
            if (r < 12)              do_op(0, 1'b1, 1'b1, k, lat);
            else if (r < 12 + p_enq) do_op(0, 1'b1, 1'b0, k, lat);
            else                     do_op(0, 1'b0, 1'b1, k, lat);
        end

        repeat (3) @(negedge clk);
        check("sb0 drained", sb0.size(), 0);
        check("sb1 drained", sb1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
